// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state encoding, default timing and width helper for the
//            multi-phase traffic controller.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    localparam int c_def_num_phases  = 4;
    localparam int c_def_cnt_w       = 8;
    localparam int c_def_min_green   = 10;
    localparam int c_def_max_green   = 40;
    localparam int c_def_ext_step    = 5;
    localparam int c_def_yellow_time = 3;
    localparam int c_def_allred_time = 1;

    // One spare code point so an out-of-range preempt target stays encodable.
    function automatic int ph_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/multi_phase_traffic_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_traffic_controller_if
// Brief    : Detector/preempt inputs and light/status outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_phase_traffic_controller_if
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = c_def_num_phases,
    parameter int PH_W       = ph_w(NUM_PHASES)
);
    logic                  tick;
    logic [NUM_PHASES-1:0] demand;
    logic [NUM_PHASES-1:0] congest;
    logic                  preempt;
    logic [PH_W-1:0]       preempt_phase;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [PH_W-1:0]       active_phase;
    logic [1:0]            ctrl_state;
    logic                  phase_done;

    modport master (
        output tick, demand, congest, preempt, preempt_phase,
        input  green, yellow, red, active_phase, ctrl_state, phase_done
    );

    modport slave (
        input  tick, demand, congest, preempt, preempt_phase,
        output green, yellow, red, active_phase, ctrl_state, phase_done
    );
endinterface : multi_phase_traffic_controller_if
`default_nettype wire

// File: rtl/rr_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_phase_arbiter
// Brief    : Combinational round-robin search for the first requesting phase
//            after ptr (mod NUM_PHASES).
// Revision : 1.0 - initial release
// ============================================================================
module rr_phase_arbiter #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 3
) (
    input  wire logic [NUM_PHASES-1:0] req,
    input  wire logic [PH_W-1:0]       ptr,
    output logic      [PH_W-1:0]       grant_idx,
    output logic                       grant_valid
);
    localparam logic [PH_W:0] c_num = (PH_W+1)'(NUM_PHASES);

    logic [2*NUM_PHASES-1:0] w_dbl;
    logic [NUM_PHASES-1:0]   w_rot;
    logic [PH_W:0]           w_off;
    logic [PH_W:0]           w_sum;

    // Bit k of w_rot is the request of phase (ptr + 1 + k) mod N.
    assign w_dbl = {req, req} >> ({1'b0, ptr} + (PH_W+1)'(1));
    assign w_rot = w_dbl[NUM_PHASES-1:0];

    always_comb begin
        grant_valid = 1'b0;
        w_off       = '0;
        for (int k = NUM_PHASES - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                grant_valid = 1'b1;
                w_off       = (PH_W+1)'(k);
            end
        end
        w_sum = {1'b0, ptr} + w_off + (PH_W+1)'(1);
        if (w_sum >= c_num) begin
            w_sum = w_sum - c_num;
        end
        grant_idx = w_sum[PH_W-1:0];
    end
endmodule : rr_phase_arbiter
`default_nettype wire

// File: rtl/multi_phase_traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_traffic_controller
// Brief    : N-phase adaptive sequencer: GREEN -> YELLOW -> ALL_RED with
//            min/max green, congestion extension and emergency preempt.
// Revision : 1.0 - initial release
// ============================================================================
module multi_phase_traffic_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = c_def_num_phases,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int MIN_GREEN   = c_def_min_green,
    parameter int MAX_GREEN   = c_def_max_green,
    parameter int EXT_STEP    = c_def_ext_step,
    parameter int YELLOW_TIME = c_def_yellow_time,
    parameter int ALLRED_TIME = c_def_allred_time
) (
    input  wire logic clk,
    input  wire logic rst,
    multi_phase_traffic_controller_if.slave bus
);
    localparam int PH_W = ph_w(NUM_PHASES);

    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_min    = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] c_max    = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] c_ext    = CNT_W'(EXT_STEP);
    localparam logic [CNT_W-1:0] c_yellow = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] c_allred = CNT_W'(ALLRED_TIME);
    localparam logic [PH_W-1:0]  c_num_ph = PH_W'(NUM_PHASES);

    if ((NUM_PHASES < 2) || (MAX_GREEN >= (1 << CNT_W)) || (MAX_GREEN < MIN_GREEN)) begin : g_param_check
        $error("multi_phase_traffic_controller: illegal parameter set");
    end

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_timer, w_timer_nxt;
    logic [CNT_W-1:0]      r_elapsed, w_elapsed_nxt;
    logic [PH_W-1:0]       r_active, w_active_nxt;
    logic                  r_phase_done, w_phase_done_nxt;

    logic [PH_W-1:0]       w_grant_idx;
    logic                  w_grant_valid;
    logic                  w_pre_valid;
    logic                  w_expire;
    logic                  w_cong_act;
    logic [NUM_PHASES-1:0] w_sel;
    logic [NUM_PHASES-1:0] w_green;
    logic [NUM_PHASES-1:0] w_yellow;
    logic [CNT_W-1:0]      w_elapsed_inc;
    logic [CNT_W-1:0]      w_ext_room;
    logic [CNT_W-1:0]      w_ext_load;

    rr_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_arb (
        .req         (bus.demand),
        .ptr         (r_active),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_pre_valid   = bus.preempt && (bus.preempt_phase < c_num_ph);
    assign w_expire      = bus.tick && (r_timer == c_one);
    assign w_sel         = {{(NUM_PHASES-1){1'b0}}, 1'b1} << r_active;
    assign w_cong_act    = |(bus.congest & w_sel);
    assign w_elapsed_inc = r_elapsed + c_one;
    // Extension is clipped so total green never passes MAX_GREEN.
    assign w_ext_room    = c_max - w_elapsed_inc;
    assign w_ext_load    = (w_ext_room < c_ext) ? w_ext_room : c_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ALL_RED;
            r_timer      <= c_allred;
            r_elapsed    <= '0;
            r_active     <= '0;
            r_phase_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_elapsed    <= w_elapsed_nxt;
            r_active     <= w_active_nxt;
            r_phase_done <= w_phase_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_elapsed_nxt    = r_elapsed;
        w_active_nxt     = r_active;
        w_phase_done_nxt = 1'b0;
        case (r_state)
            ST_ALL_RED: begin
                if (w_expire) begin
                    if (w_pre_valid || w_grant_valid) begin
                        w_state_nxt   = ST_GREEN;
                        w_active_nxt  = w_pre_valid ? bus.preempt_phase : w_grant_idx;
                        w_timer_nxt   = c_min;
                        w_elapsed_nxt = '0;
                    end else begin
                        w_timer_nxt = c_allred;
                    end
                end else if (bus.tick) begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            ST_GREEN: begin
                if (w_pre_valid && (bus.preempt_phase != r_active)) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = c_yellow;
                end else if (w_pre_valid) begin
                    // Target already green: hold it with a fresh minimum dwell.
                    w_timer_nxt   = c_min;
                    w_elapsed_nxt = '0;
                end else if (bus.tick) begin
                    w_elapsed_nxt = w_elapsed_inc;
                    if (r_timer != c_one) begin
                        w_timer_nxt = r_timer - c_one;
                    end else if (w_cong_act && (w_elapsed_inc < c_max)) begin
                        w_timer_nxt = w_ext_load;
                    end else begin
                        w_state_nxt = ST_YELLOW;
                        w_timer_nxt = c_yellow;
                    end
                end
            end
            ST_YELLOW: begin
                if (w_expire) begin
                    w_state_nxt      = ST_ALL_RED;
                    w_timer_nxt      = c_allred;
                    w_phase_done_nxt = 1'b1;
                end else if (bus.tick) begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            default: begin
                w_state_nxt = ST_ALL_RED;
                w_timer_nxt = c_allred;
            end
        endcase
    end

    assign w_green          = (r_state == ST_GREEN)  ? w_sel : '0;
    assign w_yellow         = (r_state == ST_YELLOW) ? w_sel : '0;
    assign bus.green        = w_green;
    assign bus.yellow       = w_yellow;
    assign bus.red          = ~(w_green | w_yellow);
    assign bus.active_phase = r_active;
    assign bus.ctrl_state   = r_state;
    assign bus.phase_done   = r_phase_done;
endmodule : multi_phase_traffic_controller
`default_nettype wire

// File: tb/tb_multi_phase_traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_phase_traffic_controller
// Brief    : Directed self-checking bench for the 4-phase default configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_phase_traffic_controller;
    import traffic_pkg::*;

    localparam int c_n  = 4;
    localparam int c_pw = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    multi_phase_traffic_controller_if #(.NUM_PHASES(c_n), .PH_W(c_pw)) bus ();

    multi_phase_traffic_controller #(.NUM_PHASES(c_n)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n = 0;
        while (bus.ctrl_state !== st && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 32'(bus.ctrl_state), 32'(st));
    endtask

    task automatic run_len(input logic [1:0] st, output int n);
        n = 0;
        while (bus.ctrl_state === st && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Light exclusivity and red consistency, every cycle out of reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk_eq("excl", 32'(((bus.green & bus.yellow) == 4'b0) && $onehot0(bus.green | bus.yellow)
                               && (bus.red == ~(bus.green | bus.yellow))), 32'd1);
        end
    end

    initial begin
        int len;
        int order [5];
        order = '{1, 2, 3, 0, 1};

        rst = 1'b1; bus.tick = 1'b0; bus.demand = '0; bus.congest = '0;
        bus.preempt = 1'b0; bus.preempt_phase = '0;
        cyc(2);
        chk_eq("rst_state",  32'(bus.ctrl_state),   32'd0);
        chk_eq("rst_green",  32'(bus.green),        32'h0);
        chk_eq("rst_yellow", 32'(bus.yellow),       32'h0);
        chk_eq("rst_red",    32'(bus.red),          32'hf);
        chk_eq("rst_active", 32'(bus.active_phase), 32'd0);
        chk_eq("rst_done",   32'(bus.phase_done),   32'd0);

        // Single demand on phase 2
        rst = 1'b0; bus.demand = 4'b0100; bus.tick = 1'b1;
        cyc(1);
        chk_eq("t1_green", 32'(bus.green), 32'h4);
        run_len(ST_GREEN, len);
        chk_eq("t1_green_len", len, 10);
        chk_eq("t1_yellow", 32'(bus.yellow), 32'h4);
        bus.demand = '0;
        run_len(ST_YELLOW, len);
        chk_eq("t1_yellow_len", len, 3);
        chk_eq("t1_done", 32'(bus.phase_done), 32'd1);
        cyc(1);
        chk_eq("t1_done_clr", 32'(bus.phase_done), 32'd0);
        chk_eq("t1_idle",     32'(bus.ctrl_state), 32'd0);

        // Full demand round-robin from reset
        rst = 1'b1; cyc(1);
        bus.demand = 4'b1111; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_state(ST_GREEN, "t2_reach");
            chk_eq("t2_green",  32'(bus.green), 32'(1 << order[k]));
            chk_eq("t2_active", 32'(bus.active_phase), 32'(order[k]));
            run_len(ST_GREEN, len);
            chk_eq("t2_green_len", len, 10);
            if (k == 4) bus.demand = '0;
            run_len(ST_YELLOW, len);
            chk_eq("t2_yellow_len", len, 3);
            if (k < 4) begin
                run_len(ST_ALL_RED, len);
                chk_eq("t2_allred_len", len, 1);
            end
        end

        // Congestion held: green capped at MAX_GREEN
        bus.demand = 4'b0010; bus.congest = 4'b0010;
        wait_state(ST_GREEN, "t3_reach");
        chk_eq("t3_green", 32'(bus.green), 32'h2);
        run_len(ST_GREEN, len);
        chk_eq("t3_green_len", len, 40);
        bus.demand = '0; bus.congest = '0;
        chk_eq("t3_yellow", 32'(bus.yellow), 32'h2);
        run_len(ST_YELLOW, len);

        // Congestion dropped at green tick 17
        bus.demand = 4'b0100; bus.congest = 4'b0100;
        wait_state(ST_GREEN, "t4_reach");
        chk_eq("t4_green", 32'(bus.green), 32'h4);
        cyc(16);
        bus.congest = '0;
        run_len(ST_GREEN, len);
        chk_eq("t4_green_len", 16 + len, 20);
        bus.demand = '0;
        run_len(ST_YELLOW, len);

        // Preempt to phase 3 during green of phase 1
        bus.demand = 4'b0010;
        wait_state(ST_GREEN, "t5_reach");
        chk_eq("t5_green", 32'(bus.green), 32'h2);
        cyc(3);
        bus.preempt = 1'b1; bus.preempt_phase = 3'd3; bus.demand = '0;
        cyc(1);
        chk_eq("t5_cut_state",  32'(bus.ctrl_state), 32'd2);
        chk_eq("t5_cut_yellow", 32'(bus.yellow), 32'h2);
        run_len(ST_YELLOW, len);
        chk_eq("t5_yellow_len", len, 3);
        chk_eq("t5_done", 32'(bus.phase_done), 32'd1);
        run_len(ST_ALL_RED, len);
        chk_eq("t5_allred_len", len, 1);
        chk_eq("t5_pre_green",  32'(bus.green), 32'h8);
        chk_eq("t5_pre_active", 32'(bus.active_phase), 32'd3);
        cyc(25);
        chk_eq("t5_hold", 32'(bus.green), 32'h8);
        bus.preempt = 1'b0;
        run_len(ST_GREEN, len);
        chk_eq("t5_release_len", len, 10);
        run_len(ST_YELLOW, len);

        // Out-of-range preempt target is ignored
        bus.demand = 4'b0010;
        wait_state(ST_GREEN, "t5b_reach");
        chk_eq("t5b_green", 32'(bus.green), 32'h2);
        cyc(3);
        bus.preempt = 1'b1; bus.preempt_phase = 3'd5; bus.demand = '0;
        run_len(ST_GREEN, len);
        chk_eq("t5b_green_rest", len, 7);
        chk_eq("t5b_yellow", 32'(bus.yellow), 32'h2);
        run_len(ST_YELLOW, len);
        cyc(5);
        chk_eq("t5b_idle",   32'(bus.ctrl_state),   32'd0);
        chk_eq("t5b_active", 32'(bus.active_phase), 32'd1);
        bus.preempt = 1'b0;

        // Asynchronous reset mid-yellow
        bus.demand = 4'b0100;
        wait_state(ST_YELLOW, "t6_reach");
        cyc(1);
        bus.demand = '0;
        #2 rst = 1'b1;
        #1;
        chk_eq("t6_red",    32'(bus.red),        32'hf);
        chk_eq("t6_yellow", 32'(bus.yellow),     32'h0);
        chk_eq("t6_state",  32'(bus.ctrl_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk_eq("t6_no_done", 32'(bus.phase_done), 32'd0);
            chk_eq("t6_idle",    32'(bus.ctrl_state), 32'd0);
        end
        bus.tick = 1'b0; bus.demand = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk_eq("t6_no_tick", 32'(bus.ctrl_state), 32'd0);
        end
        bus.tick = 1'b1;
        cyc(1);
        chk_eq("t6_tick_green", 32'(bus.green), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule : tb_multi_phase_traffic_controller
`default_nettype wire
